// File: rtl/reg_writeback_pkg.sv
// Shared processor types: register-file geometry and word/address types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package reg_writeback_pkg;

   localparam int REG_W  = 16;
   localparam int REG_AW = 2;
   localparam int NREGS  = 1 << REG_AW;

   typedef logic [REG_AW-1:0] reg_addr_t;
   typedef logic [REG_W-1:0]  word_t;

   // Pending register-file write: destination plus data.
   typedef struct packed {
      reg_addr_t rd;
      word_t     data;
   } wb_entry_t;

endpackage

// File: rtl/reg_writeback_tag_fifo.sv
// In-order FIFO of load destination registers (QDEPTH entries, power of two).
// Latency: a push is visible at head the cycle after it is written.
// Backpressure: push ignored when full, pop ignored when empty; full/empty are registered-state only.
module wb_tag_fifo
   import reg_writeback_pkg::*;
#(
   parameter int QDEPTH = 4
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      push,
   input  reg_addr_t push_reg,
   input  logic      pop,
   output logic      full,
   output logic      empty,
   output reg_addr_t head
);

   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam logic [PW:0] FULL_CNT = (PW+1)'(QDEPTH);

   reg_addr_t     mem [QDEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Storage array: no reset needed, occupancy is tracked by count.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_reg;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally at QDEPTH.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write-port arbiter for ALU results and in-order load returns, with load scoreboard.
// Latency: ALU 1 cycle; load 1 cycle plus 1 per consecutive ALU-valid cycle that collides with it.
// Backpressure: ALU never stalled; ld_ready = hold buffer empty; issue_ready = tag queue not full.
// Optional REG_WB_HAZARD_CHK_EN adds a sticky hazard_err output.
module reg_writeback
   import reg_writeback_pkg::*;
#(
   parameter int DW     = REG_W,
   parameter int AW     = REG_AW,
   parameter int QDEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            alu_valid,
   input  logic [AW-1:0]   alu_reg,
   input  logic [DW-1:0]   alu_data,
   input  logic            ld_issue,
   input  logic [AW-1:0]   ld_reg,
   output logic            issue_ready,
   input  logic            ld_valid,
   input  logic [DW-1:0]   ld_data,
   output logic            ld_ready,
   output logic            wr_en,
   output logic [AW-1:0]   wr_reg,
   output logic [DW-1:0]   wr_data,
   output logic [2**AW-1:0] busy
`ifdef REG_WB_HAZARD_CHK_EN
   ,
   output logic            hazard_err
`endif
);

   localparam int NR = 1 << AW;
   localparam int CW = $clog2(QDEPTH + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(QDEPTH);

   typedef struct packed {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } entry_t;

   logic      q_full;
   logic      q_empty;
   reg_addr_t q_head;
   logic      push;
   logic      ld_acc;

   entry_t    hold_q, hold_d;
   logic      hold_vld_q, hold_vld_d;
   entry_t    wr_q, wr_d;
   logic      wr_en_q, wr_en_d;
   logic      dec_en;
   logic [AW-1:0] dec_reg;

   logic [CW-1:0] cnt [NR];
   logic [NR-1:0] inc_vec;
   logic [NR-1:0] dec_vec;

   // Only accept a return when the hold slot is free and a tag exists for it.
   assign push        = ld_issue && !q_full;
   assign ld_acc      = ld_valid && !hold_vld_q && !q_empty;
   assign issue_ready = !q_full;
   assign ld_ready    = !hold_vld_q;

   wb_tag_fifo #(
      .QDEPTH (QDEPTH)
   ) u_tag_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_reg (ld_reg),
      .pop      (ld_acc),
      .full     (q_full),
      .empty    (q_empty),
      .head     (q_head)
   );

   // Write-port arbitration: ALU first, then the held load, then a bypassing load.
   always_comb begin
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      wr_d       = wr_q;
      wr_en_d    = 1'b0;
      dec_en     = 1'b0;
      dec_reg    = hold_q.rd;
      if (alu_valid) begin
         wr_en_d = 1'b1;
         wr_d    = '{rd: alu_reg, data: alu_data};
         if (ld_acc) begin
            hold_vld_d = 1'b1;
            hold_d     = '{rd: q_head, data: ld_data};
         end
      end else if (hold_vld_q) begin
         wr_en_d    = 1'b1;
         wr_d       = hold_q;
         hold_vld_d = 1'b0;
         dec_en     = 1'b1;
         dec_reg    = hold_q.rd;
      end else if (ld_acc) begin
         wr_en_d = 1'b1;
         wr_d    = '{rd: q_head, data: ld_data};
         dec_en  = 1'b1;
         dec_reg = q_head;
      end
   end

   // Hold buffer and registered write port.
   always_ff @(posedge clk) begin
      if (!reset) begin
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         wr_q       <= '0;
         wr_en_q    <= 1'b0;
      end else begin
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         wr_q       <= wr_d;
         wr_en_q    <= wr_en_d;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_reg  = wr_q.rd;
   assign wr_data = wr_q.data;

   // Per-register increment/decrement strobes for the scoreboard.
   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      if (push)   inc_vec[ld_reg]  = 1'b1;
      if (dec_en) dec_vec[dec_reg] = 1'b1;
   end

   // Outstanding-load counters; decrement lands on the same edge as the write, so busy drops with wr_en.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int r = 0; r < NR; r++) cnt[r] <= '0;
      end else begin
         for (int r = 0; r < NR; r++) begin
            if (inc_vec[r] && !dec_vec[r] && cnt[r] != CNT_MAX) begin
               cnt[r] <= cnt[r] + CW'(1);
            end else if (dec_vec[r] && !inc_vec[r] && cnt[r] != '0) begin
               cnt[r] <= cnt[r] - CW'(1);
            end
         end
      end
   end

   // A register is busy while any load to it is still outstanding.
   always_comb begin
      busy = '0;
      for (int r = 0; r < NR; r++) busy[r] = (cnt[r] != '0);
   end

`ifdef REG_WB_HAZARD_CHK_EN
   // Sticky flag for WAW-against-load, return with no tag, and issue while full.
   always_ff @(posedge clk) begin
      if (!reset) begin
         hazard_err <= 1'b0;
      end else if ((alu_valid && busy[alu_reg]) || (ld_valid && q_empty) || (ld_issue && q_full)) begin
         hazard_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Directed self-checking bench for reg_writeback.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises hold buffer and full tag queue.
module tb_reg_writeback;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_valid;
   logic [1:0]  alu_reg;
   logic [15:0] alu_data;
   logic        ld_issue;
   logic [1:0]  ld_reg;
   logic        issue_ready;
   logic        ld_valid;
   logic [15:0] ld_data;
   logic        ld_ready;
   logic        wr_en;
   logic [1:0]  wr_reg;
   logic [15:0] wr_data;
   logic [3:0]  busy;
`ifdef REG_WB_HAZARD_CHK_EN
   logic        hazard_err;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   reg_writeback dut (
      .clk         (clk),
      .reset       (reset),
      .alu_valid   (alu_valid),
      .alu_reg     (alu_reg),
      .alu_data    (alu_data),
      .ld_issue    (ld_issue),
      .ld_reg      (ld_reg),
      .issue_ready (issue_ready),
      .ld_valid    (ld_valid),
      .ld_data     (ld_data),
      .ld_ready    (ld_ready),
      .wr_en       (wr_en),
      .wr_reg      (wr_reg),
      .wr_data     (wr_data),
      .busy        (busy)
`ifdef REG_WB_HAZARD_CHK_EN
      ,
      .hazard_err  (hazard_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_wr(input string tag, input logic en, input logic [1:0] rd, input logic [15:0] dat);
      check({tag, "_en"},   32'(wr_en),   32'(en));
      check({tag, "_reg"},  32'(wr_reg),  32'(rd));
      check({tag, "_data"}, 32'(wr_data), 32'(dat));
   endtask

   initial begin
      reset     = 1'b0;
      alu_valid = 1'b0;
      alu_reg   = '0;
      alu_data  = '0;
      ld_issue  = 1'b0;
      ld_reg    = '0;
      ld_valid  = 1'b0;
      ld_data   = '0;

      // Reset state
      tick();
      tick();
      check_wr("rst", 1'b0, 2'd0, 16'h0000);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_issue_ready", 32'(issue_ready), 32'h1);
      check("rst_ld_ready", 32'(ld_ready), 32'h1);
`ifdef REG_WB_HAZARD_CHK_EN
      check("rst_hazard", 32'(hazard_err), 32'h0);
`endif
      reset = 1'b1;
      tick();

      // ALU write: one-cycle latency, single-cycle strobe, address/data hold afterwards
      alu_valid = 1'b1; alu_reg = 2'd2; alu_data = 16'h1234;
      tick();
      alu_valid = 1'b0;
      check_wr("alu", 1'b1, 2'd2, 16'h1234);
      tick();
      check_wr("alu_idle", 1'b0, 2'd2, 16'h1234);

      // Single load to reg 1, returned three cycles after issue
      ld_issue = 1'b1; ld_reg = 2'd1;
      tick();
      ld_issue = 1'b0;
      check("ld1_busy_a", 32'(busy), 32'h2);
      tick();
      check("ld1_busy_b", 32'(busy), 32'h2);
      tick();
      check("ld1_busy_c", 32'(busy), 32'h2);
      check("ld1_no_wr", 32'(wr_en), 32'h0);
      ld_valid = 1'b1; ld_data = 16'hBEEF;
      tick();
      ld_valid = 1'b0;
      check_wr("ld1", 1'b1, 2'd1, 16'hBEEF);
      check("ld1_busy_clr", 32'(busy), 32'h0);

      // ALU and load return collide: ALU first, load held one cycle
      ld_issue = 1'b1; ld_reg = 2'd3;
      tick();
      ld_issue = 1'b0;
      alu_valid = 1'b1; alu_reg = 2'd0; alu_data = 16'h0001;
      ld_valid  = 1'b1; ld_data = 16'h00AA;
      tick();
      alu_valid = 1'b0;
      ld_valid  = 1'b0;
      check_wr("col_alu", 1'b1, 2'd0, 16'h0001);
      check("col_ld_ready0", 32'(ld_ready), 32'h0);
      check("col_busy_held", 32'(busy), 32'h8);
      tick();
      check_wr("col_ld", 1'b1, 2'd3, 16'h00AA);
      check("col_ld_ready1", 32'(ld_ready), 32'h1);
      check("col_busy_clr", 32'(busy), 32'h0);
      tick();
      check("col_idle", 32'(wr_en), 32'h0);

      // Four back-to-back issues fill the tag queue; returns drain in issue order
      for (int i = 0; i < 4; i++) begin
         check("fill_issue_ready", 32'(issue_ready), 32'h1);
         ld_issue = 1'b1; ld_reg = 2'(i);
         tick();
      end
      ld_issue = 1'b0;
      check("full_issue_ready", 32'(issue_ready), 32'h0);
      check("full_busy", 32'(busy), 32'hF);
      ld_valid = 1'b1; ld_data = 16'hA000;
      tick();
      check_wr("drain0", 1'b1, 2'd0, 16'hA000);
      check("drain0_issue_ready", 32'(issue_ready), 32'h1);
      check("drain0_busy", 32'(busy), 32'hE);
      ld_data = 16'hA001;
      tick();
      check_wr("drain1", 1'b1, 2'd1, 16'hA001);
      check("drain1_busy", 32'(busy), 32'hC);
      ld_data = 16'hA002;
      tick();
      check_wr("drain2", 1'b1, 2'd2, 16'hA002);
      ld_data = 16'hA003;
      tick();
      ld_valid = 1'b0;
      check_wr("drain3", 1'b1, 2'd3, 16'hA003);
      check("drain3_busy", 32'(busy), 32'h0);

      // Two loads to the same register keep it busy until the second write
      ld_issue = 1'b1; ld_reg = 2'd2;
      tick();
      tick();
      ld_issue = 1'b0;
      check("dup_busy", 32'(busy), 32'h4);
      ld_valid = 1'b1; ld_data = 16'h0B01;
      tick();
      check_wr("dup_first", 1'b1, 2'd2, 16'h0B01);
      check("dup_busy_still", 32'(busy), 32'h4);
      ld_data = 16'h0B02;
      tick();
      ld_valid = 1'b0;
      check_wr("dup_second", 1'b1, 2'd2, 16'h0B02);
      check("dup_busy_clr", 32'(busy), 32'h0);
`ifdef REG_WB_HAZARD_CHK_EN
      check("no_hazard_yet", 32'(hazard_err), 32'h0);
`endif

      // Return with an empty tag queue is ignored
      ld_valid = 1'b1; ld_data = 16'hFFFF;
      tick();
      ld_valid = 1'b0;
      check_wr("orphan", 1'b0, 2'd2, 16'h0B02);
      check("orphan_busy", 32'(busy), 32'h0);
      check("orphan_ld_ready", 32'(ld_ready), 32'h1);
`ifdef REG_WB_HAZARD_CHK_EN
      check("orphan_hazard", 32'(hazard_err), 32'h1);
`endif

      // Reset mid-stream discards the pending load and restores reset values
      ld_issue = 1'b1; ld_reg = 2'd1;
      tick();
      ld_issue = 1'b0;
      alu_valid = 1'b1; alu_reg = 2'd0; alu_data = 16'h5555;
      tick();
      alu_valid = 1'b0;
      check_wr("pre_rst", 1'b1, 2'd0, 16'h5555);
      check("pre_rst_busy", 32'(busy), 32'h2);
      reset = 1'b0;
      tick();
      check_wr("mid_rst", 1'b0, 2'd0, 16'h0000);
      check("mid_rst_busy", 32'(busy), 32'h0);
      check("mid_rst_issue_ready", 32'(issue_ready), 32'h1);
      check("mid_rst_ld_ready", 32'(ld_ready), 32'h1);
`ifdef REG_WB_HAZARD_CHK_EN
      check("mid_rst_hazard", 32'(hazard_err), 32'h0);
`endif
      reset = 1'b1;
      ld_valid = 1'b1; ld_data = 16'h7777;
      tick();
      ld_valid = 1'b0;
      check("post_rst_no_wr", 32'(wr_en), 32'h0);

`ifdef REG_WB_HAZARD_CHK_EN
      // WAW against a pending load raises a sticky hazard flag (clear it after the orphan above)
      reset = 1'b0;
      tick();
      reset = 1'b1;
      ld_issue = 1'b1; ld_reg = 2'd3;
      tick();
      ld_issue = 1'b0;
      check("waw_pre", 32'(hazard_err), 32'h0);
      alu_valid = 1'b1; alu_reg = 2'd3; alu_data = 16'h0001;
      tick();
      alu_valid = 1'b0;
      check("waw_set", 32'(hazard_err), 32'h1);
      check("waw_busy", 32'(busy), 32'h8);
      tick();
      check("waw_sticky", 32'(hazard_err), 32'h1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-side controller for the 4 × 16-bit processor register file. It accepts single-cycle ALU results and in-order load returns from data memory and serialises them onto the register file's single write port (`wr_en`/`wr_reg`/`wr_data`). It also tracks outstanding load destinations in a per-register scoreboard so the decode stage can stall on read-after-load hazards.

## Interface
- `DW`, 16, data word width
- `AW`, 2, register address width (4 registers)
- `QDEPTH`, 4, maximum outstanding loads (power of two)

- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-low reset
- `alu_valid`  in  1  ALU result present this cycle (always accepted)
- `alu_reg`  in  AW  ALU destination register
- `alu_data`  in  DW  ALU result
- `ld_issue`  in  1  load issued to memory; its destination is pushed to the tag queue
- `ld_reg`  in  AW  destination register of the issued load
- `issue_ready`  out  1  tag queue not full; `ld_issue` is legal only when high
- `ld_valid`  in  1  load data returned (in issue order)
- `ld_data`  in  DW  returned load data
- `ld_ready`  out  1  load return is accepted this cycle
- `wr_en`  out  1  register file write strobe
- `wr_reg`  out  AW  write address
- `wr_data`  out  DW  write data
- `busy`  out  2**AW  bit r high while any load to register r is outstanding

## Operation
- Tag queue: a FIFO of `QDEPTH` destination registers. It is pushed on `ld_issue && issue_ready` and popped when a load return is accepted (`ld_valid && ld_ready`).
- Hold buffer: one entry {reg, data}. A load return is accepted into it when the buffer is empty. Its register comes from the tag queue head.
- Write arbitration (per cycle, registered into `wr_*`):
  - `alu_valid` has priority: next `wr_*` = ALU result.
  - Otherwise, if the hold buffer is full, next `wr_*` = hold entry, and the buffer empties.
  - Otherwise, if a load return is accepted and there is no ALU result, next `wr_*` = the load, bypassing the buffer.
  - Otherwise next `wr_en` = 0, and `wr_reg`/`wr_data` hold their previous values.
- `ld_ready` = hold buffer empty (registered state, not dependent on `alu_valid`).
- Scoreboard:
  - One 3-bit counter per register (saturates at `QDEPTH`).
  - Increments on an accepted `ld_issue`; decrements when that register's load is selected for `wr_*`.
  - A simultaneous increment and decrement on the same register leaves the counter unchanged.
  - `busy[r]` = counter[r] != 0.
- `ld_valid` with an empty tag queue is illegal; it is ignored and does not pop.

## Timing
- Reset (`reset` = 0 at an edge): `wr_en` = 0, `wr_reg` = 0, `wr_data` = 0, `busy` = 0, `issue_ready` = 1, `ld_ready` = 1, queue and buffer empty, `hazard_err` = 0. Reset mid-operation discards all pending loads.
- ALU latency: `alu_valid` at edge N → `wr_en` high in cycle N+1.
- Load latency: 1 cycle if no ALU conflict. If an ALU conflict occurs, +1 cycle per consecutive ALU-valid cycle.
- `busy[r]` falls in the same cycle `wr_en` rises for the last outstanding load to r.
- `issue_ready` = queue count < `QDEPTH`, computed from registered state; a same-cycle pop does not free a slot.
- Sustained throughput: one write per cycle. At most one load can wait in the hold buffer.

## Configuration
- `REG_WB_HAZARD_CHK_EN` defined:
  - Adds output `hazard_err` (1 bit, sticky until reset).
  - Set one cycle after any of:
    - `alu_valid` targeting a register whose `busy` bit is set (WAW against a pending load);
    - `ld_valid` while the tag queue is empty;
    - `ld_issue` while `issue_ready` = 0.
- Not defined: the port and logic are absent, and these events are silently ignored as described above.

## Structure
- Shared processor package holds `REG_W` = 16, `REG_AW` = 2, `NREGS` = 4, `reg_addr_t`, `word_t`. The register file and this block both import it.
- Sub-module `wb_tag_fifo`: parameterised `QDEPTH`-entry FIFO of `reg_addr_t` with push/pop/full/empty/head outputs and the same clock and reset.

## Test plan
- Reset, then `alu_valid` with reg 2, data 0x1234 → next cycle `wr_en` = 1, `wr_reg` = 2, `wr_data` = 0x1234. The following cycle `wr_en` = 0.
- `ld_issue` reg 1, 3 cycles later `ld_valid` data 0xBEEF → `busy` = 0b0010 until `wr_en` with reg 1, data 0xBEEF; `busy` = 0 in that same cycle.
- ALU (reg 0, 0x0001) and load return (reg 3, 0x00AA) in the same cycle → cycle+1 writes reg 0, and `ld_ready` = 0. Cycle+2 writes reg 3 0x00AA, and `ld_ready` = 1.
- Four `ld_issue` back-to-back → `issue_ready` = 0 after the fourth. The returns pop in order and write regs in issue order; `issue_ready` rises the cycle after the first pop.
- Two loads to reg 2 outstanding: `busy[2]` stays high after the first write and clears only with the second.
- With `REG_WB_HAZARD_CHK_EN`: `alu_valid` to a busy reg → `hazard_err` = 1 next cycle and held. Reset mid-stream → all outputs return to their reset values.
